// File: rtl/apb_bridge_arbiter_if.sv
// Requester and APB bus bundle for the two-port APB master.
// master: the arbiter/bridge side. slave: everything around it
// (both requesters and the APB completer).
interface apb_bridge_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    // requester side
    logic              req0, req1;
    logic              we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
    logic              ack0, ack1;
    logic              err0, err1;
    logic [DATA_W-1:0] rdata0, rdata1;
    logic              busy;

    // APB side
    logic [ADDR_W-1:0] PAddr;
    logic              PSelx;
    logic              PEnable;
    logic              PWrite;
    logic [DATA_W-1:0] PWData;
    logic              PReady;
    logic [DATA_W-1:0] PRData;

    modport master (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        output ack0, ack1, err0, err1, rdata0, rdata1, busy,
        output PAddr, PSelx, PEnable, PWrite, PWData,
        input  PReady, PRData
    );

    modport slave (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, err0, err1, rdata0, rdata1, busy,
        input  PAddr, PSelx, PEnable, PWrite, PWData,
        output PReady, PRData
    );
endinterface

// File: rtl/apb_bridge_arbiter.sv
// Two-port round-robin APB master: shares one APB bus between port 0
// (CPU) and port 1 (DMA/debug), sequences IDLE/SETUP/ACCESS, and ends
// transfers that see no PReady within TIMEOUT ACCESS cycles with an error.

// Per-port completion response: one-cycle ack/err, read data holding register.
module apb_bridge_arbiter_port #(
    parameter int DATA_W = 8
) (
    input  logic              PClk,
    input  logic              PResetn,
    input  logic              done,
    input  logic              timeout,
    input  logic              rd,
    input  logic [DATA_W-1:0] prdata,
    output logic              ack,
    output logic              err,
    output logic [DATA_W-1:0] rdata
);
    // ack/err pulse only on this port's completion edge; rdata only moves on reads
    always_ff @(posedge PClk or negedge PResetn) begin
        if (!PResetn) begin
            ack   <= 1'b0;
            err   <= 1'b0;
            rdata <= '0;
        end else begin
            ack <= done;
            err <= done & timeout;
            if (done && rd)
                rdata <= timeout ? '0 : prdata;
        end
    end
endmodule

module apb_bridge_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic                 PClk,
    input  logic                 PResetn,
    apb_bridge_arbiter_if.master bus
);
    localparam int NUM_PORTS = 2;
    localparam int CNT_W     = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [NUM_PORTS-1:0]             req, we, ack, err, elig, done_vec;
    logic [NUM_PORTS-1:0][ADDR_W-1:0] addr;
    logic [NUM_PORTS-1:0][DATA_W-1:0] wdata, rdata;

    // last doubles as the owner of the transfer in flight: it is updated
    // on every grant, so during SETUP/ACCESS it names the current port.
    logic              last;
    logic              win, other, load, done, tmo;
    logic [CNT_W-1:0]  wait_cnt;
    logic [ADDR_W-1:0] paddr;
    logic              pwrite;
    logic [DATA_W-1:0] pwdata;

    assign req   = {bus.req1, bus.req0};
    assign we    = {bus.we1, bus.we0};
    assign addr  = {bus.addr1, bus.addr0};
    assign wdata = {bus.wdata1, bus.wdata0};

    // a port being acked this cycle is ignored so it has time to drop req
    assign elig  = req & ~ack;
    assign other = ~last;

    // next state, grant decision and completion detection
    always_comb begin
        state_nxt = state;
        win       = last;
        load      = 1'b0;
        done      = 1'b0;
        tmo       = 1'b0;
        case (state)
            IDLE: begin
                if (|elig) begin
                    state_nxt = SETUP;
                    load      = 1'b1;
                    win       = (&elig) ? ~last : elig[1];
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                if (bus.PReady || (wait_cnt == CNT_LAST)) begin
                    done = 1'b1;
                    tmo  = ~bus.PReady;
                    // the finishing port cannot win back-to-back, so only
                    // the other port can chain straight into SETUP
                    if (req[other]) begin
                        state_nxt = SETUP;
                        load      = 1'b1;
                        win       = other;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // state register, grant pointer and ACCESS wait counter
    always_ff @(posedge PClk or negedge PResetn) begin
        if (!PResetn) begin
            state    <= IDLE;
            last     <= 1'b1;
            wait_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (load)
                last <= win;
            if (load)
                wait_cnt <= '0;
            else if (state == ACCESS && !done)
                wait_cnt <= wait_cnt + 1'b1;
        end
    end

    // winner's request is captured on grant and held until the next grant
    always_ff @(posedge PClk or negedge PResetn) begin
        if (!PResetn) begin
            paddr  <= '0;
            pwrite <= 1'b0;
            pwdata <= '0;
        end else if (load) begin
            paddr  <= addr[win];
            pwrite <= we[win];
            pwdata <= wdata[win];
        end
    end

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        assign done_vec[i] = done & ((i == 0) ? ~last : last);

        apb_bridge_arbiter_port #(.DATA_W(DATA_W)) u_port (
            .PClk    (PClk),
            .PResetn (PResetn),
            .done    (done_vec[i]),
            .timeout (tmo),
            .rd      (~pwrite),
            .prdata  (bus.PRData),
            .ack     (ack[i]),
            .err     (err[i]),
            .rdata   (rdata[i])
        );
    end

    assign bus.ack0    = ack[0];
    assign bus.ack1    = ack[1];
    assign bus.err0    = err[0];
    assign bus.err1    = err[1];
    assign bus.rdata0  = rdata[0];
    assign bus.rdata1  = rdata[1];
    assign bus.busy    = (state != IDLE);
    assign bus.PSelx   = (state != IDLE);
    assign bus.PEnable = (state == ACCESS);
    assign bus.PAddr   = paddr;
    assign bus.PWrite  = pwrite;
    assign bus.PWData  = pwdata;
endmodule

// File: doc/apb_bridge_arbiter.md
# apb_bridge_arbiter

Two-port APB master controller for the Pep9 system. It shares one APB bus between two requesters, port 0 (CPU memory interface) and port 1 (DMA/debug), using round-robin arbitration. It sequences each transfer through the IDLE/SETUP/ACCESS phases and returns read data with a one-cycle acknowledge. A PReady timeout terminates hung transfers with an error flag.

## Interface
- ADDR_W, 16, address width
- DATA_W, 8, data width
- TIMEOUT, 15, maximum ACCESS cycles before forced termination (>=1)

- PClk  in  1  clock
- PResetn  in  1  reset PResetn, asynchronous, active-low; clock PClk
- req0 / req1  in  1  transfer request, held until ack
- we0 / we1  in  1  1=write, 0=read; stable while req high
- addr0 / addr1  in  ADDR_W  transfer address; stable while req high
- wdata0 / wdata1  in  DATA_W  write data; stable while req high
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DATA_W  read data, valid during ack, held until next ack on that port
- err0 / err1  out  1  timeout flag, valid during ack
- busy  out  1  state != IDLE
- PAddr  out  ADDR_W  APB address
- PSelx  out  1  APB select
- PEnable  out  1  APB enable
- PWrite  out  1  APB direction
- PWData  out  DATA_W  APB write data
- PReady  in  1  slave ready
- PRData  in  DATA_W  slave read data

## Operation
- FSM states: IDLE (PSelx=0, PEnable=0), SETUP (PSelx=1, PEnable=0), ACCESS (PSelx=1, PEnable=1).
- IDLE: if any eligible req is high at the edge, go to SETUP. Otherwise stay.
- SETUP: always go to ACCESS.
- ACCESS, PReady=1: complete. If the other port's req is high, go to SETUP; otherwise go to IDLE.
- ACCESS, PReady=0, wait count = TIMEOUT-1: complete with error, with the same next-state rule.
- ACCESS, otherwise: stay and increment the wait counter. The counter clears on entry to SETUP and has width clog2(TIMEOUT+1).
- Arbitration is evaluated on the edge that enters SETUP.
  - Only one req high: that port wins.
  - Both high: the port not granted last wins.
  - `last` pointer resets to 1, so port 0 wins the first tie.
- Eligibility: a port whose ack is high in the current cycle is masked. Its req is ignored that cycle, which gives the requester time to drop req.
- On the edge entering SETUP, the winner's addr/we/wdata are registered into PAddr/PWrite/PWData. These hold unchanged through ACCESS and in IDLE until the next grant.
- Completion edge, normal termination:
  - ackN <= 1 for exactly one cycle.
  - errN <= 0.
  - rdataN <= PRData on reads; rdataN is unchanged on writes.
- Completion edge, timeout termination:
  - ackN <= 1, errN <= 1.
  - rdataN <= 0 on reads.
- ackN and errN are 0 in every cycle without a completion.
- The non-granted port sees no ack and simply keeps waiting.

## Timing
- Reset values:
  - state=IDLE, PSelx=0, PEnable=0, PAddr=0, PWrite=0, PWData=0.
  - ack0/1=0, err0/1=0, rdata0/1=0, busy=0, last=1, wait counter=0.
- Reset is asynchronous at any point, including mid-ACCESS. The in-flight transfer is dropped with no ack. The requester must re-issue after reset.
- Zero-wait latency: req sampled at edge E0 (IDLE) -> SETUP after E0 -> ACCESS after E1 -> PReady=1 at E2 -> ack during the cycle after E2. Ack arrives 3 cycles after req is sampled.
- Back-to-back transfers from different ports: ACCESS goes directly to SETUP with no IDLE cycle. Two transfers take 4 bus cycles.
- Same port repeating: the requester drops req in its ack cycle and raises it again at the earliest in the following cycle. At least one IDLE cycle occurs between its transfers.
- Each transfer spends at most TIMEOUT cycles in ACCESS.
- Simultaneous req0/req1 on the same edge: round-robin decides.
- A req that rises during SETUP or ACCESS waits for the current transfer to complete.

## Test plan
- Reset, then req0 write addr=0x0010, wdata=0xA5, PReady tied 1 -> SETUP then ACCESS with PAddr=0x0010, PWrite=1, PWData=0xA5; ack0 pulses 3 cycles after req; err0=0.
- req1 read addr=0xFC15, slave drives PRData=0x3C with 2 wait states -> ACCESS lasts 3 cycles; rdata1=0x3C during ack1; PAddr stable across SETUP and ACCESS.
- req0 and req1 raised on the same edge and held, each dropped on its ack -> port 0 is served first, port 1 follows with SETUP immediately after ACCESS (no IDLE); the next tie goes to port 0 again only after port 1 has been served.
- req0 read with PReady held 0, TIMEOUT=15 -> exactly 15 ACCESS cycles; ack0=1, err0=1, rdata0=0x00; FSM returns to IDLE.
- Assert PResetn low during ACCESS of a req1 write -> all outputs go to reset values immediately; no ack1 after release; a re-issued req1 completes normally.
